// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register-zero constant and the legal range of the mult/div latency.
package pipe_ctrl_pkg;

  // Controller FSM states; the value 2'b11 is never used.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Register $zero is hardwired, so a load into it can never create a hazard.
  localparam logic [4:0] REG0 = 5'd0;

  // Legal mult/div EX occupancy range and the fallback used outside it.
  localparam int MDU_LAT_MIN = 3;
  localparam int MDU_LAT_MAX = 9;
  localparam int MDU_LAT_DEF = 4;

  // Width of the BUSY down-counter; it must hold MDU_LAT_MAX-3.
  localparam int MDU_CNT_W = 3;

  // True when a mult/div latency lies inside the supported range.
  function automatic bit mdu_lat_ok(input int lat);
    return (lat >= MDU_LAT_MIN) && (lat <= MDU_LAT_MAX);
  endfunction

  // Down-counter load value: IDLE detect and DONE take one cycle each,
  // and the BUSY state itself runs for one cycle after the count hits zero.
  function automatic int mdu_load(input int lat);
    return lat - 3;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low
// reset. Used to count cycles in which the PC is held.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: drives the enable/flush controls of the PC,
// IF/ID, ID/EX, EX/MEM and MEM/WB registers. Handles load-use stalls,
// taken-branch flushes and multi-cycle mult/div occupancy of EX, and keeps
// a saturating count of PC-stall cycles.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             stat_clr,
  output logic             pcEn,
  output logic             ifidEn,
  output logic             idexEn,
  output logic             exmemEn,
  output logic             memwbEn,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             exmemFlush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  // An out-of-range latency falls back to the default rather than producing
  // a down-counter load that does not fit.
  localparam int LAT_EFF = mdu_lat_ok(MDU_LAT) ? MDU_LAT : MDU_LAT_DEF;
  localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_CNT_W'(mdu_load(LAT_EFF));

  state_t               state;
  state_t               next_state;
  logic [MDU_CNT_W-1:0] cnt;
  logic [MDU_CNT_W-1:0] cnt_next;
  logic                 load_use;

  // Load in EX writes a register the ID instruction reads; $zero never conflicts.
  assign load_use = ex_memRead && (ex_rt != REG0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // State and BUSY down-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: a mult/div seen in IDLE holds EX through BUSY, then DONE.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (ex_mdu_start) begin
          next_state = BUSY;
          cnt_next   = MDU_LOAD;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output logic: mult/div hold beats branch flush, which beats load-use stall.
  always_comb begin
    pcEn       = 1'b1;
    ifidEn     = 1'b1;
    idexEn     = 1'b1;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    exmemFlush = 1'b0;
    mdu_busy   = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE, DONE: begin
          if ((state == IDLE) && ex_mdu_start) begin
            pcEn       = 1'b0;
            ifidEn     = 1'b0;
            idexEn     = 1'b0;
            exmemFlush = 1'b1;
            mdu_busy   = 1'b1;
          end else if (ex_branch_taken) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
          end else if (load_use) begin
            pcEn      = 1'b0;
            ifidEn    = 1'b0;
            idexFlush = 1'b1;
          end
        end
        BUSY: begin
          pcEn       = 1'b0;
          ifidEn     = 1'b0;
          idexEn     = 1'b0;
          exmemFlush = 1'b1;
          mdu_busy   = 1'b1;
        end
        default: begin
          pcEn = 1'b1;
        end
      endcase
    end
  end

  // The downstream half of the pipeline never stalls.
  assign exmemEn = 1'b1;
  assign memwbEn = 1'b1;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pcEn),
    .clr   (stat_clr),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (MDU_LAT=4/CNT_W=16 and
// MDU_LAT=3/CNT_W=4) share stimulus and are compared every cycle against a
// sequence-position model of the pipeline control rules.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memRead, ex_branch_taken, ex_mdu_start, stat_clr;

  logic        pc_a, ifid_a, idex_a, exmem_a, memwb_a, ifl_a, idfl_a, exfl_a, busy_a;
  logic        pc_b, ifid_b, idex_b, exmem_b, memwb_b, ifl_b, idfl_b, exfl_b, busy_b;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;

  logic [8:0]  ctl_o [2];
  logic [15:0] cnt_o [2];

  assign ctl_o[0] = {pc_a, ifid_a, idex_a, exmem_a, memwb_a, ifl_a, idfl_a, exfl_a, busy_a};
  assign ctl_o[1] = {pc_b, ifid_b, idex_b, exmem_b, memwb_b, ifl_b, idfl_b, exfl_b, busy_b};
  assign cnt_o[0] = stall_a;
  assign cnt_o[1] = {12'd0, stall_b};

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memRead(ex_memRead), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_mdu_start(ex_mdu_start), .stat_clr(stat_clr),
    .pcEn(pc_a), .ifidEn(ifid_a), .idexEn(idex_a), .exmemEn(exmem_a), .memwbEn(memwb_a),
    .ifidFlush(ifl_a), .idexFlush(idfl_a), .exmemFlush(exfl_a), .mdu_busy(busy_a),
    .stall_cycles(stall_a)
  );

  pipe_hazard_ctrl #(.MDU_LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memRead(ex_memRead), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_mdu_start(ex_mdu_start), .stat_clr(stat_clr),
    .pcEn(pc_b), .ifidEn(ifid_b), .idexEn(idex_b), .exmemEn(exmem_b), .memwbEn(memwb_b),
    .ifidFlush(ifl_b), .idexFlush(idfl_b), .exmemFlush(exfl_b), .mdu_busy(busy_b),
    .stall_cycles(stall_b)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: seq is the cycle index of the current mult/div occupancy of EX
  // (0 = none in progress); cnt_m is the expected stall counter.
  int lat  [2] = '{4, 3};
  int cmax [2] = '{65535, 15};
  int seq  [2] = '{0, 0};
  int cnt_m[2] = '{0, 0};
  string inst [2] = '{"a", "b"};
  string names[9] = '{"pcEn", "ifidEn", "idexEn", "exmemEn", "memwbEn",
                      "ifidFlush", "idexFlush", "exmemFlush", "mdu_busy"};

  // Expected {pc,ifid,idex,exmem,memwb,ifidFl,idexFl,exmemFl,busy} for instance i.
  function automatic logic [8:0] model_ctl(int i);
    logic hz, hold;
    if (rst !== 1'b1) return 9'b111110000;
    hz = ex_memRead && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    hold = ((seq[i] == 0) && ex_mdu_start) || ((seq[i] >= 1) && (seq[i] <= lat[i] - 2));
    if (hold)                 return 9'b000110011;
    else if (ex_branch_taken) return 9'b111111100;
    else if (hz)              return 9'b001110100;
    return 9'b111110000;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urt, input logic mr, input logic [4:0] ert,
                               input logic br, input logic st, input logic clr);
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memRead = mr;
    ex_rt = ert; ex_branch_taken = br; ex_mdu_start = st; stat_clr = clr;
    if (!r) begin
      seq   = '{0, 0};
      cnt_m = '{0, 0};
    end
  endtask

  // Compare both instances, then advance the model across the coming edge.
  task automatic checkOutput(string tag);
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      e = model_ctl(i);
      for (int b = 0; b < 9; b++)
        chk($sformatf("%s/%s/%s", tag, inst[i], names[b]), 32'(ctl_o[i][8-b]), 32'(e[8-b]));
      chk($sformatf("%s/%s/stall_cycles", tag, inst[i]), 32'(cnt_o[i]), 32'(cnt_m[i]));
      if (rst === 1'b1) begin
        if (stat_clr) cnt_m[i] = 0;
        else if (!e[8] && cnt_m[i] < cmax[i]) cnt_m[i]++;
        if (seq[i] == 0) seq[i] = ex_mdu_start ? 1 : 0;
        else if (seq[i] == lat[i] - 1) seq[i] = 0;
        else seq[i]++;
      end
    end
  endtask

  task automatic step(string tag);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); step("reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); step("idle");

    // Load-use on rs, then no hazard for ex_rt=0 and for rt without use
    applyStimulus(1, 8, 0, 0, 1, 8, 0, 0, 0); step("lu_rs");
    applyStimulus(1, 8, 0, 0, 0, 8, 0, 0, 0); step("lu_rs_after");
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0); step("lu_r0");
    applyStimulus(1, 3, 8, 0, 1, 8, 0, 0, 0); step("lu_rt_unused");
    applyStimulus(1, 3, 8, 1, 1, 8, 0, 0, 0); step("lu_rt_used");

    // Mult/div held for four cycles, then released
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); step($sformatf("mdu%0d", k));
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); step($sformatf("mdu_drain%0d", k));
    end

    // Branch and load-use together in IDLE; branch during BUSY
    applyStimulus(1, 5, 0, 0, 1, 5, 1, 0, 0); step("br_lu");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); step("br_busy0");
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0); step("br_busy1");
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0); step("br_busy2");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); step("br_busy3");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); step("br_busy4");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); step("br_busy5");

    // Back-to-back mult/div: start held across DONE
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); step($sformatf("b2b%0d", k));
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); step($sformatf("b2b_drain%0d", k));
    end

    // Reset dropped in the middle of a mult/div
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); step("rst_mdu0");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); step("rst_mdu1");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0); step("rst_mdu_drop");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); step("rst_mdu_rel0");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); step("rst_mdu_rel1");

    // Saturation of the 4-bit counter, then clear under a live hazard
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, 9, 0, 0, 1, 9, 0, 0, 0); step($sformatf("sat%0d", k));
    end
    applyStimulus(1, 9, 0, 0, 1, 9, 0, 0, 1); step("sat_clr");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); step("sat_after");

    // Randomized traffic with small register numbers to provoke hazards
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 63) != 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 31) == 0));
      step($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
